// File: rtl/model_share_pkg.sv
// model_share_pkg
//   Shared types and helpers for the model_share arbiter slice.
//   MODEL_W  : width of one operand / result word.
//   MAX_LOCK : longest burst a locked requester may hold the grant for.
//   tag_t    : in-flight tag {valid, id}; id is sized for the largest NREQ.
//   rr_pick  : round-robin search returning {found, idx}.
package model_share_pkg;

   localparam int MODEL_W  = 5;
   localparam int MAX_LOCK = 4;
   localparam int MAX_REQ  = 8;
   localparam int TAG_IDW  = 3;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } lock_state_t;

   typedef struct packed {
      logic               valid;
      logic [TAG_IDW-1:0] id;
   } tag_t;

   typedef struct packed {
      logic               found;
      logic [TAG_IDW-1:0] idx;
   } pick_t;

   // First set bit of valid at or above ptr, wrapping at nreq-1 -> 0.
   function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                     input logic [TAG_IDW-1:0] ptr,
                                     input int                 nreq);
      pick_t            res;
      logic [TAG_IDW:0] lim;
      logic [TAG_IDW:0] cand;
      logic             hit;
      res = '{found: 1'b0, idx: '0};
      lim = (TAG_IDW+1)'(nreq);
      for (int i = 0; i < MAX_REQ; i++) begin
         cand      = {1'b0, ptr} + (TAG_IDW+1)'(i);
         cand      = (cand >= lim) ? (cand - lim) : cand;
         hit       = (i < nreq) && !res.found && valid[cand[TAG_IDW-1:0]];
         res.idx   = hit ? cand[TAG_IDW-1:0] : res.idx;
         res.found = res.found | hit;
      end
      return res;
   endfunction

endpackage

// File: rtl/model_share_tagpipe.sv
// model_share_tagpipe
//   LAT-deep shift register of in-flight tags plus the response register.
//   clk, rst          : clock, asynchronous active-high reset
//   issue_valid/id    : operation issued to the model this cycle and its owner
//   res_o0 / res_o1   : model results, valid when the last tag stage is valid
//   rsp_valid         : one-hot result strobe (registered)
//   rsp_id            : owner index of the result (registered)
//   rsp_o0 / rsp_o1   : registered copies of the model results
module model_share_tagpipe
   import model_share_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int LAT  = 2,
   parameter int IDW  = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               issue_valid,
   input  logic [TAG_IDW-1:0] issue_id,
   input  logic [2:-2]        res_o0,
   input  logic [-2:2]        res_o1,
   output logic [NREQ-1:0]    rsp_valid,
   output logic [IDW-1:0]     rsp_id,
   output logic [MODEL_W-1:0] rsp_o0,
   output logic [MODEL_W-1:0] rsp_o1
);

   tag_t pipe_r [LAT];
   tag_t last_s;

   assign last_s = pipe_r[LAT-1];

   // Tag shift register, aligned with the model's internal latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            pipe_r[i] <= '0;
         end
      end else begin
         pipe_r[0] <= '{valid: issue_valid, id: issue_id};
         for (int i = 1; i < LAT; i++) begin
            pipe_r[i] <= pipe_r[i-1];
         end
      end
   end

   // Response register; data only moves when a tracked result arrives.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid <= '0;
         rsp_id    <= '0;
         rsp_o0    <= '0;
         rsp_o1    <= '0;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            rsp_valid[k] <= last_s.valid && (last_s.id == TAG_IDW'(k));
         end
         if (last_s.valid) begin
            rsp_id <= IDW'(last_s.id);
            rsp_o0 <= res_o0;
            rsp_o1 <= res_o1;
         end
      end
   end

endmodule

// File: rtl/model_share_arb.sv
// model_share_arb
//   Round-robin arbiter time-sharing one fixed-latency model datapath
//   between NREQ requesters, with burst lock and tagged result return.
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : per-requester handshake, ready is the one-hot grant
//   req_lock              : keep the grant next cycle (burst, max MAX_LOCK grants)
//   req_i0/req_i1         : per-requester operands, requester k in [5k+4:5k]
//   res_valid/res_i0/i1   : operation issued to the model this cycle
//   res_o0/res_o1         : model results, LAT cycles after issue
//   rsp_valid/id/o0/o1    : registered result return to the issuing requester
module model_share_arb
   import model_share_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int LAT  = 2,
   parameter int IDW  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ-1:0]         req_lock,
   input  logic [MODEL_W*NREQ-1:0] req_i0,
   input  logic [MODEL_W*NREQ-1:0] req_i1,
   output logic                    res_valid,
   output logic [2:-2]             res_i0,
   output logic [-2:2]             res_i1,
   input  logic [2:-2]             res_o0,
   input  logic [-2:2]             res_o1,
   output logic [NREQ-1:0]         rsp_valid,
   output logic [IDW-1:0]          rsp_id,
   output logic [MODEL_W-1:0]      rsp_o0,
   output logic [MODEL_W-1:0]      rsp_o1
);

   lock_state_t        state_r;
   logic [TAG_IDW-1:0] ptr_r;
   logic [TAG_IDW-1:0] lock_id_r;
   logic [2:0]         lock_cnt_r;

   logic [MAX_REQ-1:0] valid_ext_s;
   logic [MAX_REQ-1:0] lock_ext_s;
   pick_t              rr_s;
   logic               lock_hold_s;
   logic               grant_s;
   logic [TAG_IDW-1:0] grant_idx_s;
   logic [TAG_IDW-1:0] ptr_next_s;

   // Grant selection: a live lock owner wins, otherwise round-robin from ptr.
   always_comb begin
      valid_ext_s              = '0;
      valid_ext_s[NREQ-1:0]    = req_valid;
      lock_ext_s               = '0;
      lock_ext_s[NREQ-1:0]     = req_lock;
      rr_s                     = rr_pick(valid_ext_s, ptr_r, NREQ);
      lock_hold_s              = (state_r == ST_LOCKED) && valid_ext_s[lock_id_r];
      if (rst) begin
         grant_s     = 1'b0;
         grant_idx_s = '0;
      end else if (lock_hold_s) begin
         grant_s     = 1'b1;
         grant_idx_s = lock_id_r;
      end else begin
         grant_s     = rr_s.found;
         grant_idx_s = rr_s.idx;
      end
      ptr_next_s = (grant_idx_s == TAG_IDW'(NREQ-1)) ? '0 : (grant_idx_s + TAG_IDW'(1));
   end

   // Bus mapping: one-hot ready and the granted requester's operands.
   always_comb begin
      req_ready = '0;
      res_i0    = '0;
      res_i1    = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (grant_s && (grant_idx_s == TAG_IDW'(k))) begin
            req_ready[k] = 1'b1;
            res_i0       = req_i0[MODEL_W*k +: MODEL_W];
            res_i1       = req_i1[MODEL_W*k +: MODEL_W];
         end else begin
            req_ready[k] = 1'b0;
         end
      end
      res_valid = grant_s;
   end

   // Lock FSM and round-robin pointer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r    <= ST_IDLE;
         ptr_r      <= '0;
         lock_id_r  <= '0;
         lock_cnt_r <= '0;
      end else begin
         case (state_r)
            ST_LOCKED: begin
               if (lock_hold_s) begin
                  // Owner transfers; leave on lock release or the final burst grant.
                  if (!lock_ext_s[lock_id_r] || (lock_cnt_r == 3'(MAX_LOCK-1))) begin
                     state_r    <= ST_IDLE;
                     ptr_r      <= ptr_next_s;
                     lock_cnt_r <= '0;
                  end else begin
                     lock_cnt_r <= lock_cnt_r + 3'd1;
                  end
               end else if (grant_s) begin
                  // Owner dropped valid: this cycle was arbitrated normally.
                  ptr_r      <= ptr_next_s;
                  state_r    <= lock_ext_s[grant_idx_s] ? ST_LOCKED : ST_IDLE;
                  lock_id_r  <= grant_idx_s;
                  lock_cnt_r <= 3'd1;
               end else begin
                  state_r    <= ST_IDLE;
                  lock_cnt_r <= '0;
               end
            end
            ST_IDLE: begin
               if (grant_s) begin
                  ptr_r      <= ptr_next_s;
                  state_r    <= lock_ext_s[grant_idx_s] ? ST_LOCKED : ST_IDLE;
                  lock_id_r  <= grant_idx_s;
                  lock_cnt_r <= 3'd1;
               end else begin
                  state_r    <= ST_IDLE;
                  lock_cnt_r <= '0;
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               lock_cnt_r <= '0;
            end
         endcase
      end
   end

   model_share_tagpipe #(
      .NREQ (NREQ),
      .LAT  (LAT),
      .IDW  (IDW)
   ) u_tagpipe (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (grant_s),
      .issue_id    (grant_idx_s),
      .res_o0      (res_o0),
      .res_o1      (res_o1),
      .rsp_valid   (rsp_valid),
      .rsp_id      (rsp_id),
      .rsp_o0      (rsp_o0),
      .rsp_o1      (rsp_o1)
   );

endmodule

// File: tb/tb_model_share_arb.sv
// tb_model_share_arb
//   Self-checking bench for model_share_arb (NREQ=2, LAT=2). A stub model
//   echoes the shared operands after LAT register stages; a reference
//   arbiter predicts grants and pushes expected responses to a scoreboard.
module tb_model_share_arb;

   localparam int NREQ = 2;
   localparam int LAT  = 2;
   localparam int IDW  = 1;

   logic              clk;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ-1:0]   req_lock;
   logic [5*NREQ-1:0] req_i0;
   logic [5*NREQ-1:0] req_i1;
   logic              res_valid;
   logic [2:-2]       res_i0;
   logic [-2:2]       res_i1;
   logic [2:-2]       res_o0;
   logic [-2:2]       res_o1;
   logic [NREQ-1:0]   rsp_valid;
   logic [IDW-1:0]    rsp_id;
   logic [4:0]        rsp_o0;
   logic [4:0]        rsp_o1;

   logic [4:0] stub0 [LAT];
   logic [4:0] stub1 [LAT];

   typedef struct {
      int         due;
      int         id;
      logic [4:0] o0;
      logic [4:0] o1;
   } exp_t;

   exp_t sb_q[$];

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;
   int m_ptr    = 0;
   bit m_locked = 1'b0;
   int m_lock_id  = 0;
   int m_lock_cnt = 0;
   bit m_hold     = 1'b0;

   model_share_arb #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_lock  (req_lock),
      .req_i0    (req_i0),
      .req_i1    (req_i1),
      .res_valid (res_valid),
      .res_i0    (res_i0),
      .res_i1    (res_i1),
      .res_o0    (res_o0),
      .res_o1    (res_o1),
      .rsp_valid (rsp_valid),
      .rsp_id    (rsp_id),
      .rsp_o0    (rsp_o0),
      .rsp_o1    (rsp_o1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub model: LAT-cycle echo of the shared operands.
   always_ff @(posedge clk) begin
      stub0[0] <= res_i0;
      stub1[0] <= res_i1;
      for (int j = 1; j < LAT; j++) begin
         stub0[j] <= stub0[j-1];
         stub1[j] <= stub1[j-1];
      end
   end
   assign res_o0 = stub0[LAT-1];
   assign res_o1 = stub1[LAT-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference arbiter: returns granted index or -1.
   function automatic int model_pick(input logic [NREQ-1:0] v);
      m_hold = m_locked && v[m_lock_id];
      if (m_hold) return m_lock_id;
      for (int i = 0; i < NREQ; i++) begin
         if (v[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
      end
      return -1;
   endfunction

   task automatic model_update(input int g, input logic [NREQ-1:0] l);
      if (m_hold) begin
         if (!l[g] || m_lock_cnt == 3) begin
            m_locked = 1'b0;
            m_ptr    = (g + 1) % NREQ;
         end else begin
            m_lock_cnt++;
         end
      end else if (g >= 0) begin
         m_ptr      = (g + 1) % NREQ;
         m_locked   = l[g];
         m_lock_id  = g;
         m_lock_cnt = 1;
      end else begin
         m_locked = 1'b0;
      end
   endtask

   task automatic check_rsp();
      exp_t            e;
      logic [NREQ-1:0] erv;
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
         e      = sb_q.pop_front();
         erv    = '0;
         erv[e.id] = 1'b1;
         chk("rsp_valid", 32'(rsp_valid), 32'(erv));
         chk("rsp_id", 32'(rsp_id), 32'(e.id));
         chk("rsp_o0", 32'(rsp_o0), 32'(e.o0));
         chk("rsp_o1", 32'(rsp_o1), 32'(e.o1));
      end else begin
         chk("rsp_quiet", 32'(rsp_valid), 32'd0);
      end
   endtask

   // One cycle: drive, check issue against model, push expectation, clock, check response.
   // want: expected grant from the stimulus table (-1 none, -2 model only).
   task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] l,
                       input logic [5*NREQ-1:0] a0, input logic [5*NREQ-1:0] a1,
                       input int want, input bit bitchk);
      int              g;
      logic [NREQ-1:0] erdy;
      exp_t            e;
      @(negedge clk);
      req_valid = v;
      req_lock  = l;
      req_i0    = a0;
      req_i1    = a1;
      #1;
      g    = model_pick(v);
      erdy = '0;
      if (g >= 0) erdy[g] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(erdy));
      chk("res_valid", 32'(res_valid), 32'(g >= 0));
      if (want != -2) begin
         erdy = '0;
         if (want >= 0) erdy[want] = 1'b1;
         chk("grant_table", 32'(req_ready), 32'(erdy));
      end
      if (g >= 0) begin
         chk("res_i0", 32'(res_i0), 32'(a0[5*g +: 5]));
         chk("res_i1", 32'(res_i1), 32'(a1[5*g +: 5]));
         e.due = cyc + LAT + 1;
         e.id  = g;
         e.o0  = a0[5*g +: 5];
         e.o1  = a1[5*g +: 5];
         sb_q.push_back(e);
      end else begin
         chk("res_i0_idle", 32'(res_i0), 32'd0);
         chk("res_i1_idle", 32'(res_i1), 32'd0);
      end
      if (bitchk) begin
         chk("res_i0[2]", 32'(res_i0[2]), 32'd1);
         chk("res_i0[-2]", 32'(res_i0[-2]), 32'd1);
         chk("res_i1[-2]", 32'(res_i1[-2]), 32'd1);
         chk("res_i1[2]", 32'(res_i1[2]), 32'd1);
         chk("res_i0[1]", 32'(res_i0[1]), 32'd0);
         chk("res_i1[1]", 32'(res_i1[1]), 32'd1);
      end
      @(posedge clk);
      model_update(g, l);
      cyc++;
      #1;
      check_rsp();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst       = 1'b1;
      req_valid = 2'b11;
      req_lock  = 2'b00;
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_o0", 32'(rsp_o0), 32'd0);
      chk("rst_rsp_o1", 32'(rsp_o1), 32'd0);
      sb_q.delete();
      m_ptr      = 0;
      m_locked   = 1'b0;
      m_lock_cnt = 0;
      @(posedge clk);
      cyc++;
      #1;
      chk("rst_hold_rsp", 32'(rsp_valid), 32'd0);
      chk("rst_hold_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst       = 1'b0;
      req_valid = 2'b00;
      @(posedge clk);
      cyc++;
      #1;
      check_rsp();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst       = 1'b0;
      req_valid = '0;
      req_lock  = '0;
      req_i0    = '0;
      req_i1    = '0;

      do_reset();

      // Round-robin, no lock: 0,1,0,1.
      step(2'b11, 2'b00, {5'd3, 5'd1}, {5'd4, 5'd2}, 0, 1'b0);
      step(2'b11, 2'b00, {5'd7, 5'd5}, {5'd8, 5'd6}, 1, 1'b0);
      step(2'b11, 2'b00, {5'd11, 5'd9}, {5'd12, 5'd10}, 0, 1'b0);
      step(2'b11, 2'b00, {5'd15, 5'd13}, {5'd16, 5'd14}, 1, 1'b0);

      // Bit mapping through requester 1.
      step(2'b10, 2'b00, {5'b10011, 5'b00000}, {5'b10011, 5'b00000}, 1, 1'b1);
      for (int i = 0; i < LAT + 2; i++) step(2'b00, 2'b00, '0, '0, -1, 1'b0);

      // Lock limit: four grants to 0, then 1.
      step(2'b11, 2'b01, {5'd21, 5'd20}, {5'd23, 5'd22}, 0, 1'b0);
      step(2'b11, 2'b01, {5'd21, 5'd24}, {5'd23, 5'd25}, 0, 1'b0);
      step(2'b11, 2'b01, {5'd21, 5'd26}, {5'd23, 5'd27}, 0, 1'b0);
      step(2'b11, 2'b01, {5'd21, 5'd28}, {5'd23, 5'd29}, 0, 1'b0);
      step(2'b11, 2'b01, {5'd30, 5'd28}, {5'd31, 5'd29}, 1, 1'b0);
      step(2'b00, 2'b00, '0, '0, -1, 1'b0);

      // Lock release: owner drops valid, requester 1 granted that cycle.
      step(2'b01, 2'b01, {5'd0, 5'd17}, {5'd0, 5'd18}, 0, 1'b0);
      step(2'b11, 2'b01, {5'd2, 5'd19}, {5'd3, 5'd1}, 0, 1'b0);
      step(2'b10, 2'b01, {5'd6, 5'd0}, {5'd9, 5'd0}, 1, 1'b0);
      step(2'b11, 2'b00, {5'd4, 5'd5}, {5'd6, 5'd7}, 0, 1'b0);
      for (int i = 0; i < LAT + 2; i++) step(2'b00, 2'b00, '0, '0, -1, 1'b0);

      // Pseudo-random traffic.
      for (int i = 0; i < 30; i++) begin
         step(2'($urandom), 2'($urandom), 10'($urandom), 10'($urandom), -2, 1'b0);
      end

      // Reset mid-flight: two ops in flight are discarded.
      step(2'b11, 2'b00, {5'd9, 5'd8}, {5'd7, 5'd6}, -2, 1'b0);
      step(2'b11, 2'b00, {5'd5, 5'd4}, {5'd3, 5'd2}, -2, 1'b0);
      do_reset();
      for (int i = 0; i < LAT + 3; i++) step(2'b00, 2'b00, '0, '0, -1, 1'b0);
      step(2'b11, 2'b00, {5'd1, 5'd2}, {5'd3, 5'd4}, 0, 1'b0);
      for (int i = 0; i < LAT + 2; i++) step(2'b00, 2'b00, '0, '0, -1, 1'b0);

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
